// File: rtl/counter_ctrl.sv
// counter_ctrl: synchronizes and debounces four buttons plus a 4-bit switch bank,
// and drives an external up/down counter through a run/hold FSM with a tick prescaler.
module counter_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned TICK_DIV        = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_load,
  input  logic       btn_stop,
  input  logic [3:0] sw,
  output logic       load,
  output logic       up_down,
  output logic       enable,
  output logic [3:0] d_in,
  output logic [1:0] state
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam int unsigned BUP = 0;
  localparam int unsigned BDN = 1;
  localparam int unsigned BLD = 2;
  localparam int unsigned BST = 3;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    RUN_UP   = 2'b01,
    RUN_DOWN = 2'b10,
    HOLD     = 2'b11
  } state_e;

  logic [7:0]         sync1_q, sync2_q;
  logic [3:0]         btn_s, sw_s;
  logic [3:0][CW-1:0] cnt_q, cnt_d;
  logic [3:0]         lvl_q, lvl_d, lvl_prev_q, press;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          up_down_q, up_down_d;
  logic          load_q, load_d;
  logic [3:0]    d_in_q, d_in_d;

  assign btn_s = sync2_q[3:0];
  assign sw_s  = sync2_q[7:4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {sw, btn_stop, btn_load, btn_down, btn_up};
      sync2_q <= sync1_q;
    end
  end

  // Level flips on the edge where the mismatch has already lasted DEBOUNCE_CYCLES-1 counts.
  always_comb begin
    lvl_d = lvl_q;
    cnt_d = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (btn_s[i] != lvl_q[i]) begin
        if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          lvl_d[i] = btn_s[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      lvl_q      <= '0;
      lvl_prev_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      lvl_q      <= lvl_d;
      lvl_prev_q <= lvl_q;
    end
  end

  assign press = lvl_q & ~lvl_prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      up_down_q <= 1'b1;
      load_q    <= 1'b0;
      d_in_q    <= '0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      up_down_q <= up_down_d;
      load_q    <= load_d;
      d_in_q    <= d_in_d;
    end
  end

  always_comb begin
    state_d = state_q;
    load_d  = 1'b0;
    d_in_d  = d_in_q;
    if (press[BST]) begin
      // Stop wins even where it changes nothing, so it still masks lower events.
      if (state_q == RUN_UP || state_q == RUN_DOWN) begin
        state_d = HOLD;
      end
    end else if (press[BLD]) begin
      state_d = HOLD;
      load_d  = 1'b1;
      d_in_d  = sw_s;
    end else if (press[BUP]) begin
      state_d = RUN_UP;
    end else if (press[BDN]) begin
      state_d = RUN_DOWN;
    end

    up_down_d = up_down_q;
    if (state_d == RUN_UP) begin
      up_down_d = 1'b1;
    end else if (state_d == RUN_DOWN) begin
      up_down_d = 1'b0;
    end

    presc_d = '0;
    if ((state_d == state_q) && (state_q == RUN_UP || state_q == RUN_DOWN)) begin
      presc_d = (presc_q == PW'(TICK_DIV - 1)) ? '0 : presc_q + PW'(1);
    end
  end

  always_comb begin
    state   = state_q;
    load    = load_q;
    up_down = up_down_q;
    d_in    = d_in_q;
    enable  = (state_q == RUN_UP || state_q == RUN_DOWN) &&
              (presc_q == PW'(TICK_DIV - 1));
  end

endmodule

// File: tb/tb_counter_ctrl.sv
// Testbench for counter_ctrl: directed multi-cycle sequences plus a table of
// button/switch vectors with hand-computed FSM outcomes.
module tb_counter_ctrl;

  localparam int unsigned DB = 4;
  localparam int unsigned TD = 4;

  logic       clk = 1'b0;
  logic       clk_en = 1'b0;
  logic       rst = 1'b0;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_load = 1'b0, btn_stop = 1'b0;
  logic [3:0] sw = 4'h0;
  logic       load, up_down, enable;
  logic [3:0] d_in;
  logic [1:0] state;

  int n_chk  = 0;
  int n_fail = 0;

  counter_ctrl #(.DEBOUNCE_CYCLES(DB), .TICK_DIV(TD)) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .btn_load (btn_load),
    .btn_stop (btn_stop),
    .sw       (sw),
    .load     (load),
    .up_down  (up_down),
    .enable   (enable),
    .d_in     (d_in),
    .state    (state)
  );

  always #5 if (clk_en) clk = ~clk;

  typedef struct {
    logic [3:0]  btn;   // {stop, load, down, up}
    logic [3:0]  swv;
    int unsigned hi;
    int unsigned lo;
    logic [1:0]  st;
    logic        ud;
    logic [3:0]  d;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check("load_enable_exclusive", {31'b0, load & enable}, 32'd0);
  endtask

  task automatic set_btn(input logic [3:0] m);
    btn_up   = m[0];
    btn_down = m[1];
    btn_load = m[2];
    btn_stop = m[3];
  endtask

  task automatic ticks(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_load"},    {31'b0, load},    32'd0);
    check({tag, "_enable"},  {31'b0, enable},  32'd0);
    check({tag, "_up_down"}, {31'b0, up_down}, 32'd1);
    check({tag, "_d_in"},    {28'b0, d_in},    32'd0);
    check({tag, "_state"},   {30'b0, state},   32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit found;

    vecs[0]  = '{btn: 4'b1000, swv: 4'h0, hi: 10, lo: 10, st: 2'b00, ud: 1'b1, d: 4'h0};
    vecs[1]  = '{btn: 4'b0001, swv: 4'h0, hi: 3,  lo: 20, st: 2'b00, ud: 1'b1, d: 4'h0};
    vecs[2]  = '{btn: 4'b0001, swv: 4'h0, hi: 10, lo: 10, st: 2'b01, ud: 1'b1, d: 4'h0};
    vecs[3]  = '{btn: 4'b0010, swv: 4'h0, hi: 10, lo: 10, st: 2'b10, ud: 1'b0, d: 4'h0};
    vecs[4]  = '{btn: 4'b0010, swv: 4'h0, hi: 10, lo: 10, st: 2'b10, ud: 1'b0, d: 4'h0};
    vecs[5]  = '{btn: 4'b1000, swv: 4'h0, hi: 10, lo: 10, st: 2'b11, ud: 1'b0, d: 4'h0};
    vecs[6]  = '{btn: 4'b1000, swv: 4'h0, hi: 10, lo: 10, st: 2'b11, ud: 1'b0, d: 4'h0};
    vecs[7]  = '{btn: 4'b0001, swv: 4'h0, hi: 4,  lo: 10, st: 2'b01, ud: 1'b1, d: 4'h0};
    vecs[8]  = '{btn: 4'b0100, swv: 4'h5, hi: 10, lo: 10, st: 2'b11, ud: 1'b1, d: 4'h5};
    vecs[9]  = '{btn: 4'b0010, swv: 4'h5, hi: 10, lo: 10, st: 2'b10, ud: 1'b0, d: 4'h5};
    vecs[10] = '{btn: 4'b1111, swv: 4'hA, hi: 10, lo: 10, st: 2'b11, ud: 1'b0, d: 4'h5};
    vecs[11] = '{btn: 4'b0101, swv: 4'h3, hi: 10, lo: 10, st: 2'b11, ud: 1'b0, d: 4'h3};
    vecs[12] = '{btn: 4'b0011, swv: 4'h3, hi: 10, lo: 10, st: 2'b01, ud: 1'b1, d: 4'h3};
    vecs[13] = '{btn: 4'b1010, swv: 4'h9, hi: 10, lo: 10, st: 2'b11, ud: 1'b1, d: 4'h3};
    vecs[14] = '{btn: 4'b0010, swv: 4'h9, hi: 4,  lo: 10, st: 2'b10, ud: 1'b0, d: 4'h3};
    vecs[15] = '{btn: 4'b0110, swv: 4'hF, hi: 10, lo: 10, st: 2'b11, ud: 1'b0, d: 4'hF};

    // Reset with the clock stopped: outputs must settle without any edge.
    #5 rst = 1'b1;
    #1 check_reset_outputs("rst_no_clk");
    clk_en = 1'b1;
    ticks(2);
    rst = 1'b0;

    // 3-cycle glitch on btn_up is rejected.
    set_btn(4'b0001);
    for (int unsigned k = 1; k <= 23; k++) begin
      if (k == 4) set_btn(4'b0000);
      tick();
      check("glitch_state",  {30'b0, state},  32'd0);
      check("glitch_enable", {31'b0, enable}, 32'd0);
    end

    // Held btn_up: RUN_UP after edge 7, enable after edges 10, 14, 18.
    set_btn(4'b0001);
    for (int unsigned k = 1; k <= 20; k++) begin
      tick();
      check("up_state",   {30'b0, state},   (k >= 7) ? 32'd1 : 32'd0);
      check("up_enable",  {31'b0, enable},  (k == 10 || k == 14 || k == 18) ? 32'd1 : 32'd0);
      check("up_up_down", {31'b0, up_down}, 32'd1);
    end

    // Load while running up, btn_up still held.
    sw = 4'hC;
    btn_load = 1'b1;
    for (int unsigned k = 1; k <= 12; k++) begin
      tick();
      check("load_strobe", {31'b0, load}, (k == 7) ? 32'd1 : 32'd0);
      check("load_state",  {30'b0, state}, (k >= 7) ? 32'd3 : 32'd1);
      if (k >= 7) check("load_d_in", {28'b0, d_in}, 32'h0C);
    end
    sw = 4'h2;
    set_btn(4'b0000);
    ticks(10);
    check("load_d_in_hold", {28'b0, d_in}, 32'h0C);
    check("load_hold_state", {30'b0, state}, 32'd3);

    // Stop and down together from RUN_UP: stop wins.
    set_btn(4'b0001);
    ticks(10);
    check("pre_stop_state", {30'b0, state}, 32'd1);
    set_btn(4'b0000);
    ticks(10);
    set_btn(4'b1010);
    for (int unsigned k = 1; k <= 15; k++) begin
      tick();
      check("stopdown_state", {30'b0, state}, (k >= 7) ? 32'd3 : 32'd1);
      check("stopdown_up_down", {31'b0, up_down}, 32'd1);
      if (k >= 7) check("stopdown_enable", {31'b0, enable}, 32'd0);
    end
    set_btn(4'b0000);
    ticks(10);

    // Reset in RUN_DOWN just before an enable pulse.
    set_btn(4'b0010);
    ticks(10);
    check("rundown_state", {30'b0, state}, 32'd2);
    found = 1'b0;
    for (int unsigned k = 0; k < 2 * TD && !found; k++) begin
      tick();
      if (enable) found = 1'b1;
    end
    check("rundown_pulse_seen", {31'b0, found}, 32'd1);
    ticks(TD - 1);
    #3 rst = 1'b1;
    #1 check_reset_outputs("rst_mid_run");
    set_btn(4'b0000);
    tick();
    rst = 1'b0;
    for (int unsigned k = 1; k <= 20; k++) begin
      tick();
      check("post_rst_enable", {31'b0, enable}, 32'd0);
      check("post_rst_state",  {30'b0, state},  32'd0);
    end

    // Button held through reset is accepted as a fresh press.
    set_btn(4'b0001);
    rst = 1'b1;
    ticks(3);
    rst = 1'b0;
    for (int unsigned k = 1; k <= 8; k++) begin
      tick();
      check("held_thru_rst_state", {30'b0, state}, (k >= 7) ? 32'd1 : 32'd0);
    end
    set_btn(4'b0000);

    // Table-driven vectors from a clean reset.
    rst = 1'b1;
    ticks(2);
    sw = 4'h0;
    rst = 1'b0;
    for (int unsigned v = 0; v < 16; v++) begin
      sw = vecs[v].swv;
      set_btn(vecs[v].btn);
      ticks(vecs[v].hi);
      set_btn(4'b0000);
      ticks(vecs[v].lo);
      check($sformatf("vec%0d_state", v),   {30'b0, state},   {30'b0, vecs[v].st});
      check($sformatf("vec%0d_up_down", v), {31'b0, up_down}, {31'b0, vecs[v].ud});
      check($sformatf("vec%0d_d_in", v),    {28'b0, d_in},    {28'b0, vecs[v].d});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
